// File: rtl/rx_frame_pkg.sv
// Shared definitions for the UART frame loader: FSM state encoding and frame defaults.
package rx_frame_pkg;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_PIXELS = 2'd1,
      ST_CHECK  = 2'd2
   } state_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int         DEFAULT_IMG_W     = 16;
   localparam int         DEFAULT_IMG_H     = 16;
   localparam int         FRAME_PIX         = DEFAULT_IMG_W * DEFAULT_IMG_H;

   function automatic int frame_pix(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear and flags the final cycle of the window.
module rx_idle_timer #(
   parameter int TIMEOUT_CYC = 5_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int               CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear has priority so an accept on the expiry edge wins over the timeout.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expired_o = en_i && !clr_i && (cnt_q == LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rx_frame_loader.sv
// Drains bytes from the UART receiver, hunts for the sync byte, writes one frame into image RAM
// and verifies the trailing 8-bit checksum.
import rx_frame_pkg::*;

module rx_frame_loader #(
   parameter int         IMG_W       = DEFAULT_IMG_W,
   parameter int         IMG_H       = DEFAULT_IMG_H,
   parameter int         ADDR_W      = 8,
   parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_CYC = 5_000_000
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              rx_ready_clr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic [1:0]        dbg_state
);

   localparam int                FRAME_PIX_P = frame_pix(IMG_W, IMG_H);
   localparam logic [ADDR_W-1:0] LAST_PIX    = ADDR_W'(FRAME_PIX_P - 1);

   state_e            state_q;
   logic              rx_ready_clr_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              frame_err_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [7:0]        sum_q;
   logic [7:0]        sum_d;
   logic              accept;
   logic              timer_clr;
   logic              timer_en;
   logic              timer_expired;

   // rx_ready is a level that stays high until our clear lands, so ignore it in the clear cycle.
   assign accept    = rx_ready && !rx_ready_clr_q;
   assign sum_d     = sum_q + rx_data;
   assign timer_clr = accept || (state_q == ST_HUNT);
   assign timer_en  = (state_q != ST_HUNT);

   rx_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk_i     (clk_50m),
      .rst_ni    (rst_n),
      .clr_i     (timer_clr),
      .en_i      (timer_en),
      .expired_o (timer_expired)
   );

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_HUNT;
         rx_ready_clr_q <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         busy_q         <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_err_q    <= 1'b0;
         cnt_q          <= '0;
         sum_q          <= '0;
      end else begin
         rx_ready_clr_q <= accept;
         mem_we_q       <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_err_q    <= 1'b0;
         case (state_q)
            ST_HUNT: begin
               if (accept && (rx_data == SYNC_BYTE)) begin
                  state_q <= ST_PIXELS;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  sum_q   <= '0;
               end
            end
            ST_PIXELS: begin
               if (accept) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= cnt_q;
                  mem_wdata_q <= rx_data;
                  sum_q       <= sum_d;
                  // Hold the counter on the last pixel so it never wraps.
                  if (cnt_q == LAST_PIX) begin
                     state_q <= ST_CHECK;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else if (timer_expired) begin
                  frame_err_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_HUNT;
               end
            end
            ST_CHECK: begin
               if (accept) begin
                  if (rx_data == sum_q) begin
                     frame_done_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
                  busy_q  <= 1'b0;
                  state_q <= ST_HUNT;
               end else if (timer_expired) begin
                  frame_err_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_HUNT;
               end
            end
            default: begin
               state_q <= ST_HUNT;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_ready_clr = rx_ready_clr_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign busy         = busy_q;
   assign frame_done   = frame_done_q;
   assign frame_err    = frame_err_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_rx_frame_loader.sv
// Bench for rx_frame_loader: receiver model driving bytes, a stream-level reference model
// predicting RAM writes and frame results, and a monitor comparing against the DUT.
module tb_rx_frame_loader;

   localparam int IMG_W = 4;
   localparam int IMG_H = 4;
   localparam int ADDR_W = 4;
   localparam int TO = 200;
   localparam int NPIX = IMG_W * IMG_H;
   localparam logic [7:0] SYNC = 8'hA5;

   localparam logic [1:0] EV_WRITE = 2'd1;
   localparam logic [1:0] EV_DONE = 2'd2;
   localparam logic [1:0] EV_ERR = 2'd3;

   logic              clk_50m = 1'b0;
   logic              rst_n;
   logic              rx_ready = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready_clr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              frame_done;
   logic              frame_err;
   logic [1:0]        dbg_state;

   rx_frame_loader #(
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .ADDR_W      (ADDR_W),
      .SYNC_BYTE   (SYNC),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_50m      (clk_50m),
      .rst_n        (rst_n),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_ready_clr (rx_ready_clr),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_err    (frame_err),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   always #5 clk_50m = ~clk_50m;

   int cyc = 0;
   always @(posedge clk_50m) cyc <= cyc + 1;

   // scoreboard state
   logic [17:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   // reference model: a stream walker over accepted bytes
   int         m_mode = 0;
   int         m_idx = 0;
   logic [7:0] m_sum = 8'h00;

   bit b2b_mode = 1'b0;
   int prev_b2b_clr = -1;
   int last_clr_cyc = 0;
   bit prev_clr = 1'b0, prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

   logic [7:0] pix_buf[NPIX];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_mode == 0) begin
         if (b == SYNC) begin
            m_mode = 1;
            m_idx = 0;
            m_sum = 8'h00;
         end
      end else if (m_mode == 1) begin
         exp_q.push_back({EV_WRITE, 8'(m_idx), b});
         m_sum = m_sum + b;
         m_idx++;
         if (m_idx == NPIX) m_mode = 2;
      end else begin
         exp_q.push_back({(b == m_sum) ? EV_DONE : EV_ERR, 16'h0000});
         m_mode = 0;
      end
   endtask

   task automatic model_timeout();
      if (m_mode != 0) exp_q.push_back({EV_ERR, 16'h0001});
      m_mode = 0;
   endtask

   // monitor: sampled on the falling edge
   always @(negedge clk_50m) begin
      logic [17:0] e;
      logic [1:0]  kind;
      if (!rst_n) begin
         prev_clr = 1'b0; prev_we = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
      end else begin
         if (prev_clr) check("rx_ready_clr_pulse", 32'(rx_ready_clr), 0);
         if (prev_we) check("mem_we_pulse", 32'(mem_we), 0);
         if (prev_done) check("frame_done_pulse", 32'(frame_done), 0);
         if (prev_err) check("frame_err_pulse", 32'(frame_err), 0);
         if (rx_ready_clr) begin
            if (b2b_mode && prev_b2b_clr >= 0) check("b2b_accept_spacing", 32'(cyc - prev_b2b_clr), 2);
            prev_b2b_clr = b2b_mode ? cyc : -1;
            last_clr_cyc = cyc;
         end
         if (mem_we || frame_done || frame_err) begin
            if (frame_done && frame_err) check("done_err_exclusive", 32'(frame_done & frame_err), 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_event: we=%0d done=%0d err=%0d addr=%0d data=0x%0h, none required (cycle %0d)",
                        mem_we, frame_done, frame_err, mem_addr, mem_wdata, cyc);
            end else begin
               e = exp_q.pop_front();
               kind = mem_we ? EV_WRITE : (frame_done ? EV_DONE : EV_ERR);
               check("event_kind", 32'(kind), 32'(e[17:16]));
               if (mem_we) begin
                  check("write_addr_data", 32'({{(8-ADDR_W){1'b0}}, mem_addr, mem_wdata}), 32'(e[15:0]));
                  check("busy_during_frame", 32'(busy), 1);
               end else begin
                  check("busy_at_frame_end", 32'(busy), 0);
                  check("state_at_frame_end", 32'(dbg_state), 0);
                  if (frame_err && e[0]) check("timeout_gap", 32'(cyc - last_clr_cyc), TO);
               end
            end
         end
         prev_clr = rx_ready_clr; prev_we = mem_we; prev_done = frame_done; prev_err = frame_err;
      end
   end

   // driver tasks: receiver model, all called #1 after a rising edge
   task automatic wait_clr();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk_50m);
         #1;
         if (rx_ready_clr) got = 1'b1;
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL handshake_timeout: rx_ready_clr not seen for byte 0x%0h", rx_data);
      end
   endtask

   task automatic idle(input int n);
      rx_ready = 1'b0;
      repeat (n) begin
         @(posedge clk_50m);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      model_byte(b);
      rx_data = b;
      rx_ready = 1'b1;
      wait_clr();
      if (gap > 0) idle(gap);
   endtask

   task automatic send_frame(input logic [7:0] ck_delta, input int maxgap);
      logic [7:0] s;
      s = 8'h00;
      send_byte(SYNC, $urandom_range(maxgap, 1));
      for (int i = 0; i < NPIX; i++) begin
         send_byte(pix_buf[i], $urandom_range(maxgap, 1));
         s = s + pix_buf[i];
      end
      send_byte(s + ck_delta, 2);
   endtask

   task automatic check_idle_outputs(input string name);
      check(name, 32'({rx_ready_clr, mem_we, mem_addr, mem_wdata, busy, frame_done, frame_err, dbg_state}), 0);
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk_50m);
      @(negedge clk_50m);
      check_idle_outputs("reset_outputs");
      @(posedge clk_50m);
      #1 rst_n = 1'b1;
      @(posedge clk_50m);
      #1;

      // junk before sync, counting pixels, correct checksum 0x88
      send_byte(8'h00, 1);
      send_byte(8'h13, 1);
      for (int i = 0; i < NPIX; i++) pix_buf[i] = 8'(i + 1);
      send_frame(8'h00, 1);
      idle(4);

      // same frame, checksum 0x89
      send_frame(8'h01, 1);
      idle(4);

      // partial frame then silence, then a fresh frame from address 0
      send_byte(SYNC, 1);
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
      model_timeout();
      idle(TO + 15);
      for (int i = 0; i < NPIX; i++) pix_buf[i] = 8'($urandom_range(255, 0));
      send_frame(8'h00, 2);
      idle(3);

      // sync value inside pixel data
      for (int i = 0; i < NPIX; i++) pix_buf[i] = (i % 3 == 0) ? SYNC : 8'($urandom_range(255, 0));
      send_frame(8'h00, 1);
      idle(3);

      // rx_ready held high, new byte each time the clear is seen
      b2b_mode = 1'b1;
      prev_b2b_clr = -1;
      begin
         logic [7:0] s;
         s = 8'h00;
         send_byte(SYNC, 0);
         for (int i = 0; i < NPIX; i++) begin
            pix_buf[i] = 8'($urandom_range(255, 0));
            s = s + pix_buf[i];
            send_byte(pix_buf[i], 0);
         end
         send_byte(s, 1);
      end
      b2b_mode = 1'b0;
      idle(3);

      // reset while pixel 7 is pending
      send_byte(SYNC, 1);
      for (int i = 1; i <= 6; i++) send_byte(8'(i), 1);
      rx_data = 8'h07;
      rx_ready = 1'b1;
      #2 rst_n = 1'b0;
      m_mode = 0;
      check("queue_empty_before_reset", 32'(exp_q.size()), 0);
      repeat (3) begin
         @(negedge clk_50m);
         check_idle_outputs("outputs_in_reset");
      end
      @(posedge clk_50m);
      #1 rst_n = 1'b1;
      model_byte(8'h07);
      wait_clr();
      idle(2);
      for (int i = 0; i < NPIX; i++) pix_buf[i] = 8'(i + 1);
      send_frame(8'h00, 1);
      idle(3);

      // randomized frames with junk, gaps and occasional bad checksums
      for (int f = 0; f < 6; f++) begin
         int njunk;
         logic [7:0] j;
         njunk = $urandom_range(3, 0);
         for (int k = 0; k < njunk; k++) begin
            j = 8'($urandom_range(255, 0));
            if (j == SYNC) j = 8'h00;
            send_byte(j, $urandom_range(2, 0) + 1);
         end
         for (int i = 0; i < NPIX; i++) pix_buf[i] = 8'($urandom_range(255, 0));
         send_frame(($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00, 3);
         idle($urandom_range(3, 1));
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_50m);
      @(negedge clk_50m);
      check("all_events_seen", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
